fb_fizzle_ctrl: RTL and testbench

Sequencer that owns the framebuffer write port for a fizzlefade transition. It runs in the system clock domain next to the framebuffer BRAM and counts `frame_sys` pulses for a start delay. It then walks every framebuffer address exactly once in pseudo-random order, using an internal maximal-length LFSR, and writes a fixed fade colour at a programmable rate. A start/busy/done handshake lets a top-level or scene controller chain fades.

---
 rtl/fb_fizzle_ctrl.sv | 142 ++++++++++++++
 tb/tb_fb_fizzle_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_fizzle_ctrl.sv
// Fizzlefade sequencer: waits WAIT_FRAMES frame pulses, then writes one colour to every framebuffer address once, in LFSR order.
// Optional FIZZLE_SKIP_OOR_EN: out-of-range LFSR values are stepped past one per cycle instead of consuming a write slot.
module fb_fizzle_ctrl #(
  parameter int               FB_PIXELS   = 19200,
  parameter int               ADDRW       = 15,
  parameter int               DATAW       = 4,
  parameter logic [ADDRW-1:0] LFSR_TAPS   = 15'b110000000000000,
  parameter logic [ADDRW-1:0] LFSR_SEED   = '1,
  parameter int               WAIT_FRAMES = 120,
  parameter int               RATE        = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             frame,
  input  logic [DATAW-1:0] colr,
  output logic             busy,
  output logic             done,
  output logic             fb_we,
  output logic [ADDRW-1:0] fb_addr,
  output logic [DATAW-1:0] fb_colr
);

  localparam int RW = (RATE > 1) ? $clog2(RATE) : 1;
  localparam int FW = (WAIT_FRAMES > 0) ? $clog2(WAIT_FRAMES + 1) : 1;
  localparam logic [RW-1:0]    RATE_LAST   = RW'(RATE - 1);
  localparam logic [FW-1:0]    FRAMES_LAST = FW'(WAIT_FRAMES);
  localparam logic [ADDRW:0]   PIX_LIM     = (ADDRW + 1)'(FB_PIXELS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FADE, S_ZERO} state_e;

  state_e           state_q;
  logic [ADDRW-1:0] lfsr_q;
  logic [ADDRW-1:0] lfsr_d;
  logic [RW-1:0]    rate_q;
  logic [FW-1:0]    frames_q;
  logic [DATAW-1:0] colr_q;
  logic             busy_q;
  logic             done_q;
  logic             we_q;
  logic [ADDRW-1:0] addr_q;
  logic [DATAW-1:0] wcolr_q;
  logic             slot;
  logic             in_range;
  logic             skip_oor;

  assign lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  assign slot     = (rate_q == RATE_LAST);
  assign in_range = ({1'b0, lfsr_q} < PIX_LIM);

`ifdef FIZZLE_SKIP_OOR_EN
  assign skip_oor = !in_range;
`else
  assign skip_oor = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      rate_q   <= '0;
      frames_q <= '0;
      colr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wcolr_q  <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            // busy is held one extra cycle after done so it falls after the pulse
            busy_q <= 1'b0;
            if (start) begin
              colr_q   <= colr;
              frames_q <= '0;
              rate_q   <= '0;
              lfsr_q   <= LFSR_SEED;
              busy_q   <= 1'b1;
              state_q  <= (WAIT_FRAMES == 0) ? S_FADE : S_WAIT;
            end
          end
          S_WAIT: begin
            if (frame) begin
              if (frames_q != FRAMES_LAST) frames_q <= frames_q + FW'(1);
              if (frames_q == FRAMES_LAST - FW'(1)) state_q <= S_FADE;
            end
          end
          S_FADE: begin
            if (skip_oor) begin
              // rate counter keeps running up to the slot so in-range writes stay RATE apart
              lfsr_q <= lfsr_d;
              if (!slot) rate_q <= rate_q + RW'(1);
              if (lfsr_d == LFSR_SEED) begin
                rate_q  <= '0;
                state_q <= S_ZERO;
              end
            end else if (slot) begin
              if (in_range) begin
                we_q    <= 1'b1;
                addr_q  <= lfsr_q;
                wcolr_q <= colr_q;
              end
              lfsr_q <= lfsr_d;
              rate_q <= '0;
              if (lfsr_d == LFSR_SEED) state_q <= S_ZERO;
            end else begin
              rate_q <= rate_q + RW'(1);
            end
          end
          S_ZERO: begin
            if (slot) begin
              we_q    <= 1'b1;
              addr_q  <= '0;
              wcolr_q <= colr_q;
              done_q  <= 1'b1;
              rate_q  <= '0;
              state_q <= S_IDLE;
            end else begin
              rate_q <= rate_q + RW'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign fb_we   = we_q;
  assign fb_addr = addr_q;
  assign fb_colr = wcolr_q;

endmodule

// File: tb/tb_fb_fizzle_ctrl.sv
// Directed bench for fb_fizzle_ctrl: a 20-pixel framebuffer walked by a 5-bit LFSR (taps 10100, seed 1F).
// dut_a uses WAIT_FRAMES=2/RATE=3, dut_b uses WAIT_FRAMES=0/RATE=1.
module tb_fb_fizzle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // In-range LFSR values in walk order, then the explicit address 0, and their slot index from seed.
  int EXP_ADDR[20] = '{12, 6, 3, 15, 19, 13, 18, 9, 16, 8, 4, 2, 1, 10, 5, 11, 17, 14, 7, 0};
  int SLOT[20]     = '{4, 5, 6, 9, 10, 13, 14, 15, 16, 17, 18, 19, 20, 22, 23, 25, 26, 28, 29, 31};

  logic       start_a = 1'b0, abort_a = 1'b0, frame_a = 1'b0;
  logic [3:0] colr_a = 4'h0;
  logic       busy_a, done_a, we_a;
  logic [4:0] addr_a;
  logic [3:0] wcolr_a;

  logic       start_b = 1'b0, abort_b = 1'b0, frame_b = 1'b0;
  logic [3:0] colr_b = 4'h0;
  logic       busy_b, done_b, we_b;
  logic [4:0] addr_b;
  logic [3:0] wcolr_b;

  fb_fizzle_ctrl #(.FB_PIXELS(20), .ADDRW(5), .DATAW(4), .LFSR_TAPS(5'b10100),
                   .LFSR_SEED(5'h1F), .WAIT_FRAMES(2), .RATE(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .frame(frame_a), .colr(colr_a),
    .busy(busy_a), .done(done_a), .fb_we(we_a), .fb_addr(addr_a), .fb_colr(wcolr_a));

  fb_fizzle_ctrl #(.FB_PIXELS(20), .ADDRW(5), .DATAW(4), .LFSR_TAPS(5'b10100),
                   .LFSR_SEED(5'h1F), .WAIT_FRAMES(0), .RATE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .frame(frame_b), .colr(colr_b),
    .busy(busy_b), .done(done_b), .fb_we(we_b), .fb_addr(addr_b), .fb_colr(wcolr_b));

  logic [4:0] a_addr_q[$];
  logic [3:0] a_colr_q[$];
  int         a_cyc_q[$];
  logic       a_wdone_q[$];
  int         a_ndone = 0, a_done_cyc = 0, a_fall_cyc = 0;
  logic       a_busy_prev = 1'b0;

  always @(negedge clk) begin
    if (we_a) begin
      a_addr_q.push_back(addr_a);
      a_colr_q.push_back(wcolr_a);
      a_cyc_q.push_back(cyc);
      a_wdone_q.push_back(done_a);
    end
    if (done_a) begin
      a_ndone    <= a_ndone + 1;
      a_done_cyc <= cyc;
    end
    if (a_busy_prev && !busy_a) a_fall_cyc <= cyc;
    a_busy_prev <= busy_a;
  end

  logic [4:0] b_addr_q[$];
  logic [3:0] b_colr_q[$];
  int         b_cyc_q[$];
  int         b_ndone = 0, b_done_cyc = 0;

  always @(negedge clk) begin
    if (we_b) begin
      b_addr_q.push_back(addr_b);
      b_colr_q.push_back(wcolr_b);
      b_cyc_q.push_back(cyc);
    end
    if (done_b) begin
      b_ndone    <= b_ndone + 1;
      b_done_cyc <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame_a();
    frame_a = 1'b1;
    tick(1);
    frame_a = 1'b0;
  endtask

  // Full fade on dut_a; optionally pokes start/frame/colr mid-fade, which must all be ignored.
  task automatic fade_a(input logic [3:0] c, input bit disturb);
    int base, dbase, f, guard, n;
    base  = a_addr_q.size();
    dbase = a_ndone;
    colr_a  = c;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    check_eq("busy_after_start", busy_a, 1);
    tick(4);
    pulse_frame_a();
    tick(4);
    check_eq("no_we_before_frame2", a_addr_q.size() - base, 0);
    pulse_frame_a();
    f = cyc;
    if (disturb) begin
      tick(20);
      start_a = 1'b1;
      frame_a = 1'b1;
      colr_a  = 4'h3;
      tick(1);
      start_a = 1'b0;
      frame_a = 1'b0;
    end
    guard = 0;
    while (a_ndone == dbase && guard < 400) begin
      tick(1);
      guard++;
    end
    tick(3);
    check_eq("done_count", a_ndone - dbase, 1);
    n = a_addr_q.size() - base;
    check_eq("write_count", n, 20);
    for (int i = 0; i < 20; i++) begin
      if (i < n) begin
        check_eq($sformatf("addr[%0d]", i), a_addr_q[base+i], EXP_ADDR[i]);
        check_eq($sformatf("colr[%0d]", i), a_colr_q[base+i], c);
        check_eq($sformatf("done_with_wr[%0d]", i), a_wdone_q[base+i], (i == 19) ? 1 : 0);
`ifndef FIZZLE_SKIP_OOR_EN
        check_eq($sformatf("wr_cyc[%0d]", i), a_cyc_q[base+i] - f, 3 * SLOT[i] + 3);
`else
        if (i > 0)
          check_eq($sformatf("gap_ge3[%0d]", i), (a_cyc_q[base+i] - a_cyc_q[base+i-1]) >= 3, 1);
`endif
      end
    end
`ifndef FIZZLE_SKIP_OOR_EN
    check_eq("done_cyc", a_done_cyc - f, 96);
`else
    check_eq("duration_le72", (a_done_cyc - f) <= 72, 1);
`endif
    check_eq("busy_fall_after_done", a_fall_cyc - a_done_cyc, 1);
  endtask

  initial begin
    int base, dbase, f, s, guard, n;

    // Reset state
    tick(2);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_we", we_a, 0);
    check_eq("rst_addr", addr_a, 0);
    check_eq("rst_colr", wcolr_a, 0);
    check_eq("rst_busy_b", busy_b, 0);
    rst = 1'b0;
    tick(2);

    // Handshake, full coverage, and mid-fade start/frame/colr disturbance
    fade_a(4'h7, 1'b1);
    tick(3);

    // Abort after the 5th write, on a cycle where an in-range slot is due
    base  = a_addr_q.size();
    dbase = a_ndone;
    colr_a  = 4'h9;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(2);
    pulse_frame_a();
    tick(2);
    pulse_frame_a();
    f = cyc;
    guard = 0;
    while (a_addr_q.size() - base < 5 && guard < 300) begin
      tick(1);
      guard++;
    end
    check_eq("abort_writes_before", a_addr_q.size() - base, 5);
`ifndef FIZZLE_SKIP_OOR_EN
    while (cyc < f + 41 && guard < 300) begin
      tick(1);
      guard++;
    end
    check_eq("abort_slot_cycle", cyc - f, 41);
`endif
    abort_a = 1'b1;
    tick(1);
    abort_a = 1'b0;
    check_eq("abort_busy", busy_a, 0);
    check_eq("abort_we", we_a, 0);
    tick(12);
    check_eq("abort_writes_after", a_addr_q.size() - base, 5);
    check_eq("abort_no_done", a_ndone - dbase, 0);

    // Fresh start after abort replays the sequence from the seed
    fade_a(4'h5, 1'b0);

    // WAIT_FRAMES=0, RATE=1: straight to FADE, a write on every in-range cycle
    base  = b_addr_q.size();
    dbase = b_ndone;
    colr_b  = 4'h2;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    s = cyc;
    check_eq("b_busy_after_start", busy_b, 1);
    guard = 0;
    while (b_ndone == dbase && guard < 100) begin
      tick(1);
      guard++;
    end
    tick(2);
    check_eq("b_done_count", b_ndone - dbase, 1);
    check_eq("b_done_cyc", b_done_cyc - s, 32);
    check_eq("b_busy_end", busy_b, 0);
    n = b_addr_q.size() - base;
    check_eq("b_write_count", n, 20);
    for (int i = 0; i < 20; i++) begin
      if (i < n) begin
        check_eq($sformatf("b_addr[%0d]", i), b_addr_q[base+i], EXP_ADDR[i]);
        check_eq($sformatf("b_colr[%0d]", i), b_colr_q[base+i], 2);
        check_eq($sformatf("b_wr_cyc[%0d]", i), b_cyc_q[base+i] - s, SLOT[i] + 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
